gcm_egress_unpacker: RTL and testbench

- Sits directly downstream of the AES-GCM core.
- Captures 128-bit ciphertext blocks (ct_data/ct_valid) and the 128-bit tag (tag_out/tag_valid) from the core. The core has no backpressure, so everything is buffered.
- Serialises blocks into a 32-bit valid/ready output stream, MSB word first, and appends the 4 tag words after the message's last CT block.
- Optionally compares the produced tag against an expected tag, for loopback and self-test.

---
 rtl/gcm_pkg.sv | 31 +++
 rtl/gcm_blk_fifo.sv | 66 ++++++
 rtl/gcm_egress_unpacker.sv | 140 ++++++++++++++
 tb/tb_gcm_egress_unpacker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// gcm_pkg: shared constants for the AES-GCM egress path.
//   Block/word geometry, m_type encodings, unpacker FSM state encodings,
//   and a helper that selects one 32-bit word of a 128-bit block, MSB word first.
package gcm_pkg;

  localparam int BLK_W         = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;

  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLK - 1);

  localparam logic TYPE_CT  = 1'b0;
  localparam logic TYPE_TAG = 1'b1;

  localparam logic [0:0] S_CT  = 1'b0;
  localparam logic [0:0] S_TAG = 1'b1;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                 input logic [1:0]       idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/gcm_blk_fifo.sv
// gcm_blk_fifo: synchronous first-word-fall-through FIFO of 128-bit blocks.
//   clk      clock
//   rst      synchronous active-low reset (empties the FIFO)
//   wr_en    push wr_data (accepted when not full, or when full with a same-cycle pop)
//   wr_data  block to push
//   rd_en    pop the head block (ignored when empty)
//   rd_data  head block, valid whenever empty=0
//   count    occupancy in blocks
//   full     count == DEPTH
//   empty    count == 0
module gcm_blk_fifo
  import gcm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [BLK_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [BLK_W-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [BLK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // When full, the slot under wr_ptr is the head being popped this cycle,
  // so overwriting it is safe.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcm_egress_unpacker.sv
// gcm_egress_unpacker: buffers ciphertext blocks and the tag from the AES-GCM
// core and serialises them onto a 32-bit valid/ready stream, MSB word first,
// with the 4 tag words following the last CT block of their message.
//   clk, rst             clock, synchronous active-low reset
//   ct_data/ct_valid     128-bit CT block strobe from the core
//   tag_in/tag_valid     128-bit tag strobe from the core
//   verify_en/exp_tag    optional compare of tag_in against exp_tag at capture
//   m_data/m_valid/m_ready  output word stream
//   m_type               0 = CT word, 1 = tag word
//   m_last               high on the 4th tag word
//   auth_done/auth_ok    compare pulse / held result
//   ovf_err              sticky: [0] CT block dropped, [1] tag dropped
//
// state | meaning
// S_CT  | presenting head FIFO block words (idle when FIFO empty)
// S_TAG | presenting the pending tag words 0..3
module gcm_egress_unpacker
  import gcm_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BLK_W-1:0]  ct_data,
  input  logic              ct_valid,
  input  logic [BLK_W-1:0]  tag_in,
  input  logic              tag_valid,
  input  logic              verify_en,
  input  logic [BLK_W-1:0]  exp_tag,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_type,
  output logic              m_last,
  output logic              auth_done,
  output logic              auth_ok,
  output logic [1:0]        ovf_err
);

  logic [0:0]       state, state_n;
  logic [1:0]       word_idx, word_idx_n;
  logic [BLK_W-1:0] tag_reg;
  logic             tag_pend, tag_pend_n;
  logic [CNT_W-1:0] tag_pos, tag_pos_n;
  logic [CNT_W-1:0] count_n;

  logic [BLK_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  logic word_pop, blk_pop, tag_done, push, capture;

  gcm_blk_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (ct_data),
    .rd_en   (blk_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid  = (state == S_TAG) || !fifo_empty;
  assign m_type   = (state == S_TAG) ? TYPE_TAG : TYPE_CT;
  assign m_last   = (state == S_TAG) && (word_idx == LAST_WORD);
  assign m_data   = (state == S_TAG) ? blk_word(tag_reg, word_idx) :
                    fifo_empty       ? '0 : blk_word(fifo_head, word_idx);

  assign word_pop = m_valid && m_ready;
  assign blk_pop  = (state == S_CT)  && word_pop && (word_idx == LAST_WORD);
  assign tag_done = (state == S_TAG) && word_pop && (word_idx == LAST_WORD);
  assign push     = ct_valid && (!fifo_full || blk_pop);
  assign capture  = tag_valid && !tag_pend;

  always_comb begin
    count_n = fifo_count;
    if (push && !blk_pop) count_n = fifo_count + 1'b1;
    if (blk_pop && !push) count_n = fifo_count - 1'b1;
  end

  // tag_pos counts the CT blocks still ahead of the pending tag.
  always_comb begin
    tag_pos_n = tag_pos;
    if (capture) begin
      tag_pos_n = count_n;
    end else if (tag_pend && blk_pop && (tag_pos != '0)) begin
      tag_pos_n = tag_pos - 1'b1;
    end
  end

  always_comb begin
    tag_pend_n = tag_pend;
    if (capture)  tag_pend_n = 1'b1;
    if (tag_done) tag_pend_n = 1'b0;
  end

  assign word_idx_n = word_pop ? word_idx + 1'b1 : word_idx;

  // Decide on next-cycle values so the switch to S_TAG happens in the same
  // edge that dequeues the last block ahead of the tag; the FSM never shows
  // a CT word it would then have to withdraw.
  always_comb begin
    state_n = state;
    case (state)
      S_CT:    if (tag_pend_n && (tag_pos_n == '0) && (word_idx_n == 2'd0)) state_n = S_TAG;
      default: if (tag_done) state_n = S_CT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_CT;
      word_idx  <= 2'd0;
      tag_reg   <= '0;
      tag_pend  <= 1'b0;
      tag_pos   <= '0;
      auth_done <= 1'b0;
      auth_ok   <= 1'b0;
      ovf_err   <= 2'b00;
    end else begin
      state     <= state_n;
      word_idx  <= word_idx_n;
      tag_pend  <= tag_pend_n;
      tag_pos   <= tag_pos_n;
      if (capture) tag_reg <= tag_in;
      auth_done <= capture && verify_en;
      if (capture && verify_en) auth_ok <= (tag_in == exp_tag);
      if (ct_valid && !push)    ovf_err[0] <= 1'b1;
      if (tag_valid && tag_pend) ovf_err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gcm_egress_unpacker.sv
module tb_gcm_egress_unpacker;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ct_data;
  logic         ct_valid;
  logic [127:0] tag_in;
  logic         tag_valid;
  logic         verify_en;
  logic [127:0] exp_tag;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_type;
  logic         m_last;
  logic         auth_done;
  logic         auth_ok;
  logic [1:0]   ovf_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] got_d[$];
  logic        got_t[$];
  logic        got_l[$];
  logic [31:0] exp_d[$];
  logic        exp_t[$];
  logic        exp_l[$];

  always #5 clk = ~clk;

  gcm_egress_unpacker #(.FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ct_data   (ct_data),
    .ct_valid  (ct_valid),
    .tag_in    (tag_in),
    .tag_valid (tag_valid),
    .verify_en (verify_en),
    .exp_tag   (exp_tag),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_type    (m_type),
    .m_last    (m_last),
    .auth_done (auth_done),
    .auth_ok   (auth_ok),
    .ovf_err   (ovf_err)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic add_blk(input logic [127:0] b, input logic typ);
    for (int k = 0; k < 4; k++) begin
      exp_d.push_back(b[127-32*k -: 32]);
      exp_t.push_back(typ);
      exp_l.push_back(typ && (k == 3));
    end
  endtask

  task automatic pulse_ct(input logic [127:0] b);
    ct_data  = b;
    ct_valid = 1'b1;
    @(negedge clk);
    ct_valid = 1'b0;
  endtask

  task automatic pulse_tag(input logic [127:0] t, input logic ven, input logic [127:0] et);
    tag_in    = t;
    verify_en = ven;
    exp_tag   = et;
    tag_valid = 1'b1;
    @(negedge clk);
    tag_valid = 1'b0;
    verify_en = 1'b0;
  endtask

  // Drains n words; toggle=1 drives m_ready 1,0,1,0... and checks that a
  // stalled word stays put. Returns at a negedge after the last pop.
  task automatic collect(input int n, input bit toggle);
    int          cyc;
    logic        pv, pr, pt, pl;
    logic [31:0] pd;
    cyc = 0; pv = 1'b0; pr = 1'b0; pt = 1'b0; pl = 1'b0; pd = '0;
    got_d.delete(); got_t.delete(); got_l.delete();
    while (got_d.size() < n && cyc < 400) begin
      @(negedge clk);
      if (pv && !pr) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, pd);
        check("stall_type", m_type, pt);
        check("stall_last", m_last, pl);
      end
      m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_t.push_back(m_type);
        got_l.push_back(m_last);
      end
      pv = m_valid; pr = m_ready; pd = m_data; pt = m_type; pl = m_last;
      cyc++;
    end
    check("collect_count", got_d.size(), n);
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < got_d.size()) begin
        check($sformatf("%s_data%0d", name, i), got_d[i], exp_d[i]);
        check($sformatf("%s_type%0d", name, i), got_t[i], exp_t[i]);
        check($sformatf("%s_last%0d", name, i), got_l[i], exp_l[i]);
      end
    end
    exp_d.delete(); exp_t.delete(); exp_l.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] b;
    logic [127:0] t;

    rst = 1'b0; ct_data = '0; ct_valid = 1'b0; tag_in = '0; tag_valid = 1'b0;
    verify_en = 1'b0; exp_tag = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_m_type", m_type, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_auth_done", auth_done, 1'b0);
    check("rst_auth_ok", auth_ok, 1'b0);
    check("rst_ovf_err", ovf_err, 2'b00);
    rst = 1'b1;
    @(negedge clk);

    // 1: single block, m_ready=1, latency N+1..N+4, then tag
    m_ready = 1'b1;
    b = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    pulse_ct(b);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_valid%0d", k), m_valid, 1'b1);
      check($sformatf("t1_data%0d", k), m_data, b[127-32*k -: 32]);
      check($sformatf("t1_type%0d", k), m_type, 1'b0);
      @(negedge clk);
    end
    check("t1_idle", m_valid, 1'b0);
    t = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    pulse_tag(t, 1'b0, '0);
    check("t1_no_auth", auth_done, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_tvalid%0d", k), m_valid, 1'b1);
      check($sformatf("t1_tdata%0d", k), m_data, t[127-32*k -: 32]);
      check($sformatf("t1_ttype%0d", k), m_type, 1'b1);
      check($sformatf("t1_tlast%0d", k), m_last, k == 3);
      @(negedge clk);
    end
    check("t1_tidle", m_valid, 1'b0);

    // 2: three blocks + tag with m_ready toggling
    m_ready = 1'b0;
    pulse_ct(128'h10000001_10000002_10000003_10000004); add_blk(128'h10000001_10000002_10000003_10000004, 1'b0);
    pulse_ct(128'h20000001_20000002_20000003_20000004); add_blk(128'h20000001_20000002_20000003_20000004, 1'b0);
    pulse_ct(128'h30000001_30000002_30000003_30000004); add_blk(128'h30000001_30000002_30000003_30000004, 1'b0);
    pulse_tag(128'hA2A2A2A2_B2B2B2B2_C2C2C2C2_D2D2D2D2, 1'b0, '0);
    add_blk(128'hA2A2A2A2_B2B2B2B2_C2C2C2C2_D2D2D2D2, 1'b1);
    collect(16, 1'b1);
    compare_stream("t2");

    // 3: overflow with m_ready=0, 17 pulses into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      b = {32'(32'hC000_0000 + i*4), 32'(32'hC000_0001 + i*4),
           32'(32'hC000_0002 + i*4), 32'(32'hC000_0003 + i*4)};
      pulse_ct(b);
      if (i < 16) add_blk(b, 1'b0);
    end
    check("t3_ovf", ovf_err, 2'b01);
    collect(64, 1'b0);
    compare_stream("t3");
    repeat (3) @(negedge clk);
    check("t3_no_extra", m_valid, 1'b0);

    // 4: tag A ordered between two messages
    pulse_ct(128'h41414141_41414141_41414141_41414141);
    pulse_ct(128'h42424242_42424242_42424242_42424242);
    pulse_tag(128'hAAAA0000_AAAA1111_AAAA2222_AAAA3333, 1'b0, '0);
    pulse_ct(128'h43434343_43434343_43434343_43434343);
    pulse_ct(128'h44444444_44444444_44444444_44444444);
    add_blk(128'h41414141_41414141_41414141_41414141, 1'b0);
    add_blk(128'h42424242_42424242_42424242_42424242, 1'b0);
    add_blk(128'hAAAA0000_AAAA1111_AAAA2222_AAAA3333, 1'b1);
    add_blk(128'h43434343_43434343_43434343_43434343, 1'b0);
    add_blk(128'h44444444_44444444_44444444_44444444, 1'b0);
    collect(20, 1'b0);
    compare_stream("t4");

    // 5: tag compare pass/fail, and tag drop while pending
    t = 128'h5555AAAA_12345678_9ABCDEF0_0F0F0F0F;
    pulse_tag(t, 1'b1, t);
    check("t5_done_pulse", auth_done, 1'b1);
    check("t5_ok", auth_ok, 1'b1);
    @(negedge clk);
    check("t5_done_clear", auth_done, 1'b0);
    check("t5_ok_held", auth_ok, 1'b1);
    pulse_tag(128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 1'b1, '0);
    check("t5_ovf_tag", ovf_err, 2'b11);
    check("t5_drop_no_auth", auth_done, 1'b0);
    add_blk(t, 1'b1);
    collect(4, 1'b0);
    compare_stream("t5a");
    t = 128'h66667777_88889999_AAAABBBB_CCCCDDDD;
    pulse_tag(t, 1'b1, t ^ 128'h1);
    check("t5_bad_done", auth_done, 1'b1);
    check("t5_bad_ok", auth_ok, 1'b0);
    add_blk(t, 1'b1);
    collect(4, 1'b0);
    compare_stream("t5b");

    // 6: reset mid-block after word 1 popped
    m_ready = 1'b1;
    b = 128'h60606060_61616161_62626262_63636363;
    pulse_ct(b);
    check("t6_w0", m_data, 32'h60606060);
    @(negedge clk);
    check("t6_w1", m_data, 32'h61616161);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", m_valid, 1'b0);
    check("t6_rst_ovf", ovf_err, 2'b00);
    check("t6_rst_data", m_data, 32'h0);
    rst = 1'b1;
    b = 128'h70717273_74757677_78797A7B_7C7D7E7F;
    pulse_ct(b);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t6_fresh_valid%0d", k), m_valid, 1'b1);
      check($sformatf("t6_fresh_data%0d", k), m_data, b[127-32*k -: 32]);
      @(negedge clk);
    end
    check("t6_fresh_idle", m_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
